cdb_broadcast_arbiter: RTL and testbench
========================================

# cdb_broadcast_arbiter

Parametrised multi-source common data bus for the Tomasulo back end. Up to NUM_SRC functional units offer completed results (tag + data) via valid/ready handshakes. A round-robin (or fixed-priority) arbiter selects one winner per cycle, and its result is broadcast one cycle later on a registered bus to the reservation stations, register status table and reorder logic. A flush input squashes arbitration and the pending broadcast on branch mispredict.

## Interface

Parameters:
- NUM_SRC, 4, number of producing functional units (2..8)
- TAG_W, 5, reservation-station tag width
- DATA_W, 32, result width
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority with lowest index winning

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- src_valid  in  NUM_SRC  per-source result offered
- src_tag  in  NUM_SRC*TAG_W  packed tags; source i occupies bits [i*TAG_W +: TAG_W]
- src_data  in  NUM_SRC*DATA_W  packed data, same packing as src_tag
- src_ready  out  NUM_SRC  one-hot or zero; grant to the source this cycle
- flush  in  1  squash grant this cycle and the broadcast pending for next cycle
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast data
- cdb_src  out  $clog2(NUM_SRC)  index of the source that produced the broadcast

## Operation

- src_ready is combinational from src_valid, flush and the priority pointer.
- src_ready is all-zero when flush=1 or when no src_valid bit is set.
- A transfer on source i occurs when src_valid[i] and src_ready[i] are both high.
- A source keeps valid, tag and data stable until it is granted. Its tag and data must not change while it waits.
- Round-robin: search starts at pointer ptr and wraps modulo NUM_SRC. The first valid source wins.
  - After a grant to source i, ptr becomes (i+1) mod NUM_SRC.
  - ptr does not change on idle cycles or flush cycles.
- FIXED_PRIO=1: ptr is ignored and held at 0. The lowest valid index wins. Starvation is permitted.
- On a transfer, the output registers load tag, data and winner index, and cdb_valid goes high on the next edge.
- With no transfer, cdb_valid goes low. cdb_tag, cdb_data and cdb_src hold their last values.
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, ptr=0.
- Reset is asynchronous. Asserting rst mid-operation clears the outputs immediately, with no edge needed, and discards any granted result.

## Timing

- Latency is 1 cycle: a grant at edge t appears on cdb_* after edge t.
- Throughput is one broadcast per cycle. Back-to-back grants to different sources, or to the same source, are legal.
- Flush and valid in the same cycle: no grant, ptr unchanged, cdb_valid=0 after the edge.
- A flush does not retract a broadcast that is already visible on the outputs during the flush cycle. That broadcast completes normally.
- The flush lasts one cycle. Sources whose valid is still high are eligible on the next cycle.
- With a single source asserted, it wins regardless of ptr.
- All sources asserted under round-robin: grants rotate ptr, ptr+1, …, and each source waits at most NUM_SRC-1 cycles.

## Structure

- Package cdb_pkg holds:
  - default TAG_W and DATA_W constants
  - a function for source-index width
  - a cdb_bus_t struct {valid, tag, data, src} shared with the reservation-station and ROB snoop logic
- One sub-module: rr_arbiter.
  - Parameters: NUM_REQ, FIXED_PRIO.
  - Inputs: req, enable (= !flush), ptr.
  - Outputs: one-hot grant, binary grant index.
  - Owns the ptr register.
- The top level does the operand muxing and holds the output register.

## Test plan

- Reset, NUM_SRC=4, round-robin:
  - Assert rst mid-stream while cdb_valid=1 with tag 0x1A → outputs go to 0 before the next edge. After release, ptr=0.
- Single source:
  - src_valid=4'b0100, tag 0x07, data 0xDEADBEEF → src_ready=4'b0100 the same cycle.
  - Next cycle: cdb_valid=1, tag 0x07, data 0xDEADBEEF, cdb_src=2.
- All four valid for 8 cycles, each source holding a distinct tag → grant order 0,1,2,3,0,1,2,3. cdb_valid stays 1 on every cycle.
- Contention with waiting:
  - Sources 1 and 3 valid with ptr=2 → source 3 wins first, then source 1.
  - Source 1's tag and data are unchanged when they are broadcast.
- Flush:
  - Sources 0 and 2 valid with flush=1 → src_ready=0. The next cycle cdb_valid=0 and ptr is unchanged.
  - The following cycle, source 0 is granted.
- FIXED_PRIO=1: sources 0 and 3 both valid continuously for 5 cycles → source 0 is granted every cycle and source 3 never is.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, index-width helper and the bus
// record snooped by the reservation stations and the reorder buffer.
package cdb_pkg;

  localparam int CDB_TAG_W   = 5;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_MAX_SRC = 8;

  // Never returns 0 so a two-source bus still has a one-bit index.
  function automatic int src_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CDB_SRC_W = src_idx_w(CDB_MAX_SRC);

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_broadcast_arbiter_rr_arbiter.sv
// Round-robin / fixed-priority single-winner arbiter. Owns the rotation
// pointer, which only advances on an actual grant.
module rr_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IDX_W     = src_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  logic [IDX_W-1:0] cand_idx;
  int               base;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    base      = FIXED_PRIO ? 0 : int'(ptr_q);
    // Search ptr, ptr+1, ... wrapping modulo NUM_REQ; first requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = base + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        grant[cand_idx]  = 1'b1;
        grant_idx        = cand_idx;
      end
    end
    if (!enable) begin
      grant = '0;
      found = 1'b0;
    end

    ptr_d = ptr_q;
    if (!FIXED_PRIO && found) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Multi-source common data bus: arbitrate one completed result per cycle
// and broadcast it from a register on the following cycle.
module cdb_broadcast_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int TAG_W      = CDB_TAG_W,
  parameter int DATA_W     = CDB_DATA_W,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IDX_W     = src_idx_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [IDX_W-1:0]          cdb_src
);

  logic [TAG_W-1:0]  tag_arr  [NUM_SRC];
  logic [DATA_W-1:0] data_arr [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign tag_arr[gi]  = src_tag[gi*TAG_W +: TAG_W];
      assign data_arr[gi] = src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  rr_arbiter #(
    .NUM_REQ    (NUM_SRC),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (src_valid),
    .enable    (~flush),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign src_ready = grant;

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  src_q, src_d;

  // Payload holds across idle cycles so snoopers can still read the last tag.
  always_comb begin
    valid_d = |grant;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    if (|grant) begin
      tag_d  = tag_arr[grant_idx];
      data_d = data_arr[grant_idx];
      src_d  = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter: a round-robin instance and a
// fixed-priority instance, checked against hand-computed expectations.
module tb_cdb_broadcast_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [3:0]   valid_a, ready_a;
  logic [19:0]  tag_a;
  logic [127:0] data_a;
  logic         flush_a;
  logic         cdb_valid_a;
  logic [4:0]   cdb_tag_a;
  logic [31:0]  cdb_data_a;
  logic [1:0]   cdb_src_a;

  // Fixed-priority instance
  logic [3:0]   valid_b, ready_b;
  logic [19:0]  tag_b;
  logic [127:0] data_b;
  logic         flush_b;
  logic         cdb_valid_b;
  logic [4:0]   cdb_tag_b;
  logic [31:0]  cdb_data_b;
  logic [1:0]   cdb_src_b;

  cdb_broadcast_arbiter #(.NUM_SRC(4), .TAG_W(5), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .src_valid(valid_a), .src_tag(tag_a), .src_data(data_a),
    .src_ready(ready_a), .flush(flush_a), .cdb_valid(cdb_valid_a), .cdb_tag(cdb_tag_a),
    .cdb_data(cdb_data_a), .cdb_src(cdb_src_a)
  );

  cdb_broadcast_arbiter #(.NUM_SRC(4), .TAG_W(5), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .src_valid(valid_b), .src_tag(tag_b), .src_data(data_b),
    .src_ready(ready_b), .flush(flush_b), .cdb_valid(cdb_valid_b), .cdb_tag(cdb_tag_b),
    .cdb_data(cdb_data_b), .cdb_src(cdb_src_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, obs);
    end
  endtask

  task automatic set_a(input int i, input logic [4:0] t, input logic [31:0] d);
    tag_a[i*5 +: 5]   = t;
    data_a[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cdb(input string name, input logic v, input logic [4:0] t,
                         input logic [31:0] d, input logic [1:0] s);
    chk({name, ".valid"}, 64'(cdb_valid_a), 64'(v));
    chk({name, ".tag"},   64'(cdb_tag_a),   64'(t));
    chk({name, ".data"},  64'(cdb_data_a),  64'(d));
    chk({name, ".src"},   64'(cdb_src_a),   64'(s));
  endtask

  initial begin
    rst = 1'b1;
    valid_a = '0; tag_a = '0; data_a = '0; flush_a = 1'b0;
    valid_b = '0; tag_b = '0; data_b = '0; flush_b = 1'b0;
    #1;
    chk_cdb("reset", 1'b0, 5'h00, 32'h0, 2'd0);
    chk("reset.ready", 64'(ready_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single source 2
    set_a(2, 5'h07, 32'hDEADBEEF);
    valid_a = 4'b0100;
    #1 chk("single.ready", 64'(ready_a), 64'b0100);
    tick();
    chk_cdb("single.bcast", 1'b1, 5'h07, 32'hDEADBEEF, 2'd2);

    // Single source 1 moves ptr to 2
    set_a(1, 5'h11, 32'h11112222);
    valid_a = 4'b0010;
    #1 chk("src1.ready", 64'(ready_a), 64'b0010);
    tick();
    valid_a = 4'b0000;
    chk_cdb("src1.bcast", 1'b1, 5'h11, 32'h11112222, 2'd1);

    // Contention: 1 and 3 with ptr=2 -> 3 first, then 1
    set_a(1, 5'h0B, 32'hB0B0B0B0);
    set_a(3, 5'h0D, 32'hD0D0D0D0);
    valid_a = 4'b1010;
    #1 chk("cont.ready0", 64'(ready_a), 64'b1000);
    tick();
    valid_a = 4'b0010;
    chk_cdb("cont.bcast3", 1'b1, 5'h0D, 32'hD0D0D0D0, 2'd3);
    #1 chk("cont.ready1", 64'(ready_a), 64'b0010);
    tick();
    valid_a = 4'b0000;
    chk_cdb("cont.bcast1", 1'b1, 5'h0B, 32'hB0B0B0B0, 2'd1);
    #1 chk("idle.ready", 64'(ready_a), 64'h0);
    tick();
    chk_cdb("idle.hold", 1'b0, 5'h0B, 32'hB0B0B0B0, 2'd1);

    // Grant source 2 so ptr=3, then flush with sources 0 and 2 valid
    set_a(2, 5'h15, 32'h15151515);
    valid_a = 4'b0100;
    #1 chk("pre.ready", 64'(ready_a), 64'b0100);
    tick();
    chk_cdb("pre.bcast", 1'b1, 5'h15, 32'h15151515, 2'd2);
    set_a(0, 5'h03, 32'h03030303);
    set_a(2, 5'h16, 32'h16161616);
    valid_a = 4'b0101;
    flush_a = 1'b1;
    #1 chk("flush.ready", 64'(ready_a), 64'h0);
    chk("flush.visible", 64'(cdb_valid_a), 64'h1);
    tick();
    flush_a = 1'b0;
    chk_cdb("flush.after", 1'b0, 5'h15, 32'h15151515, 2'd2);
    #1 chk("postflush.ready", 64'(ready_a), 64'b0001);
    tick();
    valid_a = 4'b0100;
    chk_cdb("postflush.bcast0", 1'b1, 5'h03, 32'h03030303, 2'd0);
    #1 chk("postflush.ready2", 64'(ready_a), 64'b0100);
    tick();
    valid_a = 4'b0000;
    chk_cdb("postflush.bcast2", 1'b1, 5'h16, 32'h16161616, 2'd2);

    // Asynchronous reset while a broadcast is visible
    set_a(3, 5'h1A, 32'h1A1A1A1A);
    valid_a = 4'b1000;
    #1 chk("rst.ready", 64'(ready_a), 64'b1000);
    tick();
    valid_a = 4'b0000;
    chk_cdb("rst.before", 1'b1, 5'h1A, 32'h1A1A1A1A, 2'd3);
    #2 rst = 1'b1;
    #1 chk_cdb("rst.async", 1'b0, 5'h00, 32'h0, 2'd0);
    #2 rst = 1'b0;

    // All four valid: rotation from ptr=0
    for (int i = 0; i < 4; i++) set_a(i, 5'(8 + i), 32'hA0000000 + 32'(i));
    valid_a = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rot%0d.ready", k), 64'(ready_a), 64'(4'b0001 << (k % 4)));
      tick();
      chk_cdb($sformatf("rot%0d", k), 1'b1, 5'(8 + (k % 4)),
              32'hA0000000 + 32'(k % 4), 2'(k % 4));
    end
    valid_a = 4'b0000;
    tick();
    chk("rot.end.valid", 64'(cdb_valid_a), 64'h0);

    // Fixed priority: 0 and 3 always valid, 0 always wins
    tag_b[0 +: 5]    = 5'h01; data_b[0 +: 32]  = 32'h00000001;
    tag_b[15 +: 5]   = 5'h02; data_b[96 +: 32] = 32'h00000002;
    valid_b = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("fp%0d.ready", k), 64'(ready_b), 64'b0001);
      tick();
      chk($sformatf("fp%0d.valid", k), 64'(cdb_valid_b), 64'h1);
      chk($sformatf("fp%0d.src", k), 64'(cdb_src_b), 64'h0);
      chk($sformatf("fp%0d.tag", k), 64'(cdb_tag_b), 64'h01);
    end
    valid_b = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
